// File: rtl/fmdll_pkg.sv
// Shared types and helpers for the FMDLL fine-delay-line controller.
// Holds FDL geometry, controller state / step-direction enums and the thermometer encoder.
package fmdll_pkg;

    localparam int FDL_STAGES = 6;
    localparam int FDL_W      = FDL_STAGES;
    localparam int LVL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    // MSB-first fill: level n sets the top n bits of the code.
    function automatic logic [FDL_W-1:0] level_to_therm(input logic [LVL_W-1:0] level);
        logic [FDL_W-1:0] t;
        t = '0;
        for (int i = 0; i < FDL_W; i++) begin
            if (i < int'(level)) begin
                t[FDL_W-1-i] = 1'b1;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/fdl_vote_filter.sv
// Signed up/down vote accumulator; flags a step when the net count reaches +/-FILT_LEN.
// The accumulator is held at zero whenever the controller is not tracking.
module fdl_vote_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic i_active,
    input  logic i_valid,
    input  logic i_up,
    input  logic i_dn,
    output logic o_step_up,
    output logic o_step_dn
);

    localparam int ACC_W = $clog2(FILT_LEN) + 2;
    localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(FILT_LEN);
    localparam logic signed [ACC_W-1:0] THR_N = -THR_P;
    localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_delta;
    logic signed [ACC_W-1:0] w_acc_next;

    always_comb begin
        w_delta = '0;
        if (i_valid && i_up && !i_dn) begin
            w_delta = ONE;
        end else if (i_valid && i_dn && !i_up) begin
            w_delta = -ONE;
        end
        w_acc_next = r_acc + w_delta;
        o_step_up  = i_active && (w_acc_next == THR_P);
        o_step_dn  = i_active && (w_acc_next == THR_N);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (!i_active || o_step_up || o_step_dn) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: rtl/fdl_step_ctrl.sv
// FDL loop controller: filters phase-detector votes, steps the fine line one stage per decision,
// hands wrap-around to the coarse line as carry/borrow pulses and tracks lock from direction reversals.
module fdl_step_ctrl
    import fmdll_pkg::*;
#(
    parameter int FILT_LEN    = 4,
    parameter int UPDATE_WAIT = 3,
    parameter int LOCK_CNT    = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    // pd_up/pd_dn are sampled only on edges where pd_valid=1; there is no back-pressure,
    // and votes arriving outside TRACK are dropped.
    input  logic             pd_valid,
    input  logic             pd_up,
    input  logic             pd_dn,
    input  logic             cdl_max,
    input  logic             cdl_min,
    output logic [FDL_W-1:0] Q,
    output logic             cdl_inc,
    output logic             cdl_dec,
    output logic             locked,
    output logic             sat,
    output logic [1:0]       o_dbg_state
);

    localparam int WAIT_W = (UPDATE_WAIT < 2) ? 1 : $clog2(UPDATE_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(UPDATE_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(FDL_STAGES);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [3:0]        LOCK_THR  = 4'(LOCK_CNT);

    state_t             r_state, w_state_next;
    dir_t               r_last, w_last_next, w_dir;
    logic [LVL_W-1:0]   r_level, w_level_next;
    logic [FDL_W-1:0]   r_q;
    logic [WAIT_W-1:0]  r_wait, w_wait_next;
    logic [3:0]         r_rev, w_rev_next, w_rev_up;
    logic               r_inc, w_inc_next;
    logic               r_dec, w_dec_next;
    logic               r_locked, w_locked_next;
    logic               r_sat, w_sat_next;
    logic               w_active, w_step_up, w_step_dn, w_step;

    assign w_active = enable && (r_state == ST_TRACK);
    assign w_step   = w_step_up | w_step_dn;

    fdl_vote_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .clk_in    (clk_in),
        .rst       (rst),
        .i_active  (w_active),
        .i_valid   (pd_valid),
        .i_up      (pd_up),
        .i_dn      (pd_dn),
        .o_step_up (w_step_up),
        .o_step_dn (w_step_dn)
    );

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_TRACK;
                ST_TRACK: begin
                    if (w_step && (UPDATE_WAIT != 0)) begin
                        w_state_next = ST_WAIT;
                        w_wait_next  = WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    w_wait_next = r_wait - WAIT_ONE;
                    if (r_wait <= WAIT_ONE) begin
                        w_state_next = ST_TRACK;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Level stepping with carry/borrow into the coarse line; saturation only when the CDL is pinned.
    always_comb begin
        w_level_next = r_level;
        w_inc_next   = 1'b0;
        w_dec_next   = 1'b0;
        w_sat_next   = r_sat;
        if (w_step_up) begin
            if (r_level < LVL_MAX) begin
                w_level_next = r_level + LVL_ONE;
                w_sat_next   = 1'b0;
            end else if (!cdl_max) begin
                w_level_next = '0;
                w_inc_next   = 1'b1;
                w_sat_next   = 1'b0;
            end else begin
                w_sat_next   = 1'b1;
            end
        end else if (w_step_dn) begin
            if (r_level != '0) begin
                w_level_next = r_level - LVL_ONE;
                w_sat_next   = 1'b0;
            end else if (!cdl_min) begin
                w_level_next = LVL_MAX;
                w_dec_next   = 1'b1;
                w_sat_next   = 1'b0;
            end else begin
                w_sat_next   = 1'b1;
            end
        end
    end

    always_comb begin
        w_dir         = w_step_up ? DIR_UP : DIR_DN;
        w_rev_up      = (r_rev == 4'hF) ? r_rev : r_rev + 4'd1;
        w_rev_next    = r_rev;
        w_locked_next = r_locked;
        w_last_next   = r_last;
        if (!enable || (r_state == ST_IDLE)) begin
            w_rev_next    = '0;
            w_locked_next = 1'b0;
        end else if (w_step) begin
            w_last_next = w_dir;
            if ((r_last != DIR_NONE) && (r_last != w_dir)) begin
                w_rev_next = w_rev_up;
                if (w_rev_up >= LOCK_THR) begin
                    w_locked_next = 1'b1;
                end
            end else if (r_last == w_dir) begin
                w_rev_next    = '0;
                w_locked_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wait   <= '0;
            r_level  <= '0;
            r_q      <= '0;
            r_inc    <= 1'b0;
            r_dec    <= 1'b0;
            r_sat    <= 1'b0;
            r_rev    <= '0;
            r_locked <= 1'b0;
            r_last   <= DIR_NONE;
        end else begin
            r_state  <= w_state_next;
            r_wait   <= w_wait_next;
            r_level  <= w_level_next;
            r_q      <= level_to_therm(w_level_next);
            r_inc    <= w_inc_next;
            r_dec    <= w_dec_next;
            r_sat    <= w_sat_next;
            r_rev    <= w_rev_next;
            r_locked <= w_locked_next;
            r_last   <= w_last_next;
        end
    end

    assign Q           = r_q;
    assign cdl_inc     = r_inc;
    assign cdl_dec     = r_dec;
    assign locked      = r_locked;
    assign sat         = r_sat;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fdl_step_ctrl.sv
// Scoreboard bench for fdl_step_ctrl: a behavioural loop model predicts the outputs after every edge.
// Directed sequences cover wrap, saturation, vote cancellation and lock; a randomized phase follows.
module tb_fdl_step_ctrl;

    localparam int FILT_LEN    = 4;
    localparam int UPDATE_WAIT = 3;
    localparam int LOCK_CNT    = 4;

    logic       clk_in   = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b0;
    logic       pd_valid = 1'b0;
    logic       pd_up    = 1'b0;
    logic       pd_dn    = 1'b0;
    logic       cdl_max  = 1'b0;
    logic       cdl_min  = 1'b0;
    logic [5:0] Q;
    logic       cdl_inc, cdl_dec, locked, sat;
    logic [1:0] o_dbg_state;

    always #5 clk_in = ~clk_in;

    fdl_step_ctrl #(
        .FILT_LEN    (FILT_LEN),
        .UPDATE_WAIT (UPDATE_WAIT),
        .LOCK_CNT    (LOCK_CNT)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .pd_valid    (pd_valid),
        .pd_up       (pd_up),
        .pd_dn       (pd_dn),
        .cdl_max     (cdl_max),
        .cdl_min     (cdl_min),
        .Q           (Q),
        .cdl_inc     (cdl_inc),
        .cdl_dec     (cdl_dec),
        .locked      (locked),
        .sat         (sat),
        .o_dbg_state (o_dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];   // {Q, cdl_inc, cdl_dec, locked, sat}

    // CDL limit flags the driver applies on the next cycle
    bit t_cmax = 1'b0;
    bit t_cmin = 1'b0;

    // Behavioural model: mode 0 = disabled, 1 = tracking, 2 = settling; direction is +1/-1, 0 = none yet
    int m_level, m_acc, m_mode, m_settle, m_rev, m_last;
    bit m_inc, m_dec, m_locked, m_sat;

    function automatic logic [5:0] therm(input int lvl);
        logic [5:0] t;
        t = '0;
        for (int i = 0; i < lvl; i++) t[5-i] = 1'b1;
        return t;
    endfunction

    task automatic model_reset();
        m_level = 0; m_acc = 0; m_mode = 0; m_settle = 0; m_rev = 0; m_last = 0;
        m_inc = 0; m_dec = 0; m_locked = 0; m_sat = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit u, input bit d,
                              input bit cmax, input bit cmin);
        int dir;
        int nl;
        m_inc = 0;
        m_dec = 0;
        if (!en) begin
            m_mode = 0; m_acc = 0; m_rev = 0; m_locked = 0;
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
            return;
        end
        if (m_mode == 2) begin
            m_settle = m_settle - 1;
            if (m_settle == 0) m_mode = 1;
            return;
        end
        if (!v || (u == d)) return;
        m_acc = m_acc + (u ? 1 : -1);
        if ((m_acc != FILT_LEN) && (m_acc != -FILT_LEN)) return;
        dir   = (m_acc > 0) ? 1 : -1;
        m_acc = 0;
        if (UPDATE_WAIT > 0) begin
            m_mode   = 2;
            m_settle = UPDATE_WAIT;
        end
        nl = m_level + dir;
        if (nl >= 0 && nl <= 6) begin
            m_level = nl; m_sat = 0;
        end else if (dir > 0 && !cmax) begin
            m_level = 0; m_inc = 1; m_sat = 0;
        end else if (dir < 0 && !cmin) begin
            m_level = 6; m_dec = 1; m_sat = 0;
        end else begin
            m_sat = 1;
        end
        if (m_last != 0) begin
            if (dir != m_last) begin
                m_rev = (m_rev >= 15) ? 15 : m_rev + 1;
                if (m_rev >= LOCK_CNT) m_locked = 1;
            end else begin
                m_rev = 0; m_locked = 0;
            end
        end
        m_last = dir;
    endtask

    // Driver: one clock of stimulus; the predicted post-edge outputs go to the scoreboard
    task automatic cyc(input bit en, input bit v, input bit u, input bit d);
        @(negedge clk_in);
        enable   = en;
        pd_valid = v;
        pd_up    = u;
        pd_dn    = d;
        cdl_max  = t_cmax;
        cdl_min  = t_cmin;
        model_step(en, v, u, d, t_cmax, t_cmin);
        exp_q.push_back({therm(m_level), m_inc, m_dec, m_locked, m_sat});
    endtask

    task automatic vote(input int dir, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, dir >= 0, dir <= 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step(input int dir);
        vote(dir, FILT_LEN);
        idle(UPDATE_WAIT);
    endtask

    task automatic check_now(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_now({tag, "_q"},   Q, 6'b000000);
        check_now({tag, "_inc"}, {5'b0, cdl_inc}, 6'b0);
        check_now({tag, "_dec"}, {5'b0, cdl_dec}, 6'b0);
        check_now({tag, "_lck"}, {5'b0, locked},  6'b0);
        check_now({tag, "_sat"}, {5'b0, sat},     6'b0);
    endtask

    // Monitor: compares the DUT against the head of the scoreboard just after each active edge
    always @(posedge clk_in) begin
        logic [9:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({Q, cdl_inc, cdl_dec, locked, sat} !== e) begin
                n_fail++;
                $display("FAIL out t=%0t: got Q=%b inc=%b dec=%b lck=%b sat=%b expected Q=%b inc=%b dec=%b lck=%b sat=%b",
                         $time, Q, cdl_inc, cdl_dec, locked, sat, e[9:4], e[3], e[2], e[1], e[0]);
            end
            n_tests++;
            if (cdl_inc && cdl_dec) begin
                n_fail++;
                $display("FAIL pulse_excl t=%0t: got inc=1 dec=1 expected at most one", $time);
            end
        end
    end

    initial begin
        int bias;
        model_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("por");
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        idle(1);

        // first step after four up votes, then votes inside the settle window are dropped
        vote(1, 4);
        vote(1, 3);
        idle(1);

        // climb to the top, then carry into the CDL
        repeat (5) step(1);
        step(1);
        // borrow from the CDL back to the top
        step(-1);
        // top with CDL pinned: saturate
        t_cmax = 1'b1;
        step(1);
        t_cmax = 1'b0;
        repeat (6) step(-1);
        t_cmin = 1'b1;
        step(-1);
        step(1);
        t_cmin = 1'b0;

        // cancelling votes never reach the threshold
        vote(1, 2);
        vote(-1, 2);
        vote(0, 1);
        idle(1);

        // five alternating steps lock, two same-direction steps unlock
        step(1); step(-1); step(1); step(-1); step(1);
        step(1); step(1);
        step(-1); step(1); step(-1); step(1); step(-1);
        // drop enable in the settle window
        vote(1, 4);
        idle(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // randomized traffic with shifting vote bias and occasional CDL limits / disables
        bias = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 30 == 0) begin
                case ($urandom_range(0, 2))
                    0:       bias = 10;
                    1:       bias = 50;
                    default: bias = 90;
                endcase
            end
            if ($urandom_range(0, 63) == 0) t_cmax = ~t_cmax;
            if ($urandom_range(0, 63) == 0) t_cmin = ~t_cmin;
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias);
        end
        t_cmax = 1'b0;
        t_cmin = 1'b0;

        // reset mid-cycle right after a borrow pulse: everything clears immediately
        idle(1);
        for (int i = 0; i < 7; i++) step(-1);
        vote(-1, 4);
        while (m_dec == 1'b0) vote(-1, 4);
        @(posedge clk_in);
        #3 rst = 1'b1;
        model_reset();
        #1 check_reset_outputs("mid_rst");
        @(negedge clk_in);
        rst = 1'b0;
        idle(1);
        step(1);
        step(-1);
        idle(2);

        @(posedge clk_in);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
